step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Pattern sequencer directly upstream of the synth core. Replaces the fixed
//  trig button and constant osc_count.
//  Steps through a programmable STEPS-entry pattern at a fixed tempo. For each
//  enabled step it drives a gated trig level (ADSR attack/decay/sustain while
//  high, release when low) and that step's pulse half-period on osc_count.
// PARAMETERS
//  STEPS       8      pattern length; power of two, 2..32
//  TICK_DIV    50000  clk cycles per tempo tick, >=2
//  STEP_TICKS  25     ticks per step, >=2
//  GATE_TICKS  12     ticks trig stays high per enabled step; 1..STEP_TICKS-1
//  OSC_W       8      osc_count width, matches the synth
//  DEF_OSC     66     osc_count loaded into every pattern entry at reset
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active-high
//  run          in   1      1 = sequence plays; 0 = stopped
//  pat_we       in   1      pattern write strobe
//  pat_addr     in   $clog2(STEPS)  pattern entry to write
//  pat_en       in   1      entry enable; 0 = rest step
//  pat_osc      in   OSC_W  entry pulse half-period
//  trig         out  1      gate to synth
//  osc_count    out  OSC_W  pulse half-period to synth
//  step_idx     out  $clog2(STEPS)  index of the current step
//  step_strobe  out  1      1-cycle pulse at each step start
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; trig=0; osc_count=DEF_OSC; step_idx=0; step_strobe=0
//   - prescaler and tick counter cleared
//   - all pattern entries = {en=1, osc=DEF_OSC}
//  Prescaler: counts 0..TICK_DIV-1 and emits tick when the count reaches TICK_DIV-1.
//   It is held cleared while state=IDLE.
//  FSM states: IDLE, GATE, REST. tick_cnt counts ticks within a step, 0..STEP_TICKS-1.
//  IDLE:
//   - trig=0; osc_count holds its last value
//   - if run=1 -> GATE at the next edge with step_idx=0 and tick_cnt=0
//   - on that edge: step_strobe=1; osc_count <= pattern[0].osc
//  GATE:
//   - trig = pattern entry's en, latched at step start
//   - on the tick where tick_cnt==GATE_TICKS-1 -> REST
//  REST:
//   - trig=0
//   - on the tick where tick_cnt==STEP_TICKS-1 -> GATE
//   - on that edge: step_idx <= step_idx+1, wrapping STEPS-1 -> 0; tick_cnt=0;
//     step_strobe=1; latch en/osc of the new entry
//  run=0 in GATE or REST:
//   - -> IDLE at the next edge; trig=0 the cycle after the edge
//   - step_idx resets to 0; a restart always begins at step 0
//  Latency: step start edge -> trig/osc_count valid at the same edge (registered
//   outputs). First trig is 1 cycle after run rises.
//  osc_count changes only at step start. It holds through REST so the release
//   tail keeps its pitch.
//  Pattern writes:
//   - accepted in any state; take effect when that entry next starts
//   - write to the entry being latched in the same cycle: latch sees the OLD
//     content (read-before-write)
//  Rest step (en=0): trig stays 0 for the whole step; osc_count still updates.
//  Static checks (elaboration): GATE_TICKS < STEP_TICKS; STEPS power of two.
// STRUCTURE
//  Package seq_pkg: FSM state encoding (IDLE/GATE/REST); pattern entry struct
//   {en, osc}; DEF_OSC.
//  Sub-module tick_gen(TICK_DIV): clk, rst, clr, tick.
//  Pattern storage: register array in step_sequencer, not a RAM macro; async reset needed.
// TESTING (sim params: TICK_DIV=4, STEP_TICKS=4, GATE_TICKS=2, STEPS=4)
//  1 Reset then run=1 -> after 1 cycle trig=1, osc_count=66, step_strobe 1 cycle;
//    trig falls 8 cycles later; next step_strobe 16 cycles after first.
//  2 Write {1,40},{0,50},{1,60},{1,70} then run -> osc_count 40,50,60,70,40...;
//    trig pulses on steps 0,2,3 only; step_idx wraps 3->0.
//  3 Drop run mid-GATE of step 2 -> trig=0 within 1 cycle, step_idx=0;
//    rerun starts at step 0 with osc=40.
//  4 Write entry 1 {1,99} during step 0 -> step 1 plays osc=99.
//    Write entry 1 in the exact step-1 start cycle -> old value latched.
//  5 Assert rst mid-REST -> outputs return to reset values immediately (async).
//    Pattern back to all {1,66}.
//  6 run held 1 across 3 full pattern loops -> exactly 12 step_strobes at
//    16-cycle spacing; no jitter.

Source files
------------

// File: rtl/seq_pkg.sv
// Package: seq_pkg
// Shared definitions for the step sequencer that feeds the synth core.
//   seq_state_t  : sequencer FSM encoding (IDLE / GATE / REST)
//   pat_entry_t  : one pattern entry {en, osc}
//   SEQ_OSC_W    : osc_count width used by the synth core
//   SEQ_DEF_OSC  : half-period loaded into every pattern entry at reset
//   is_pow2()    : constant helper for elaboration-time parameter checks
package seq_pkg;

  localparam int SEQ_OSC_W   = 8;
  localparam int SEQ_DEF_OSC = 66;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    REST = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic                 en;
    logic [SEQ_OSC_W-1:0] osc;
  } pat_entry_t;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/step_sequencer_tick_gen.sv
// Module: tick_gen
// Tempo prescaler. Counts 0..TICK_DIV-1 and flags tick for the single cycle
// in which the count sits at TICK_DIV-1, then wraps to 0.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high
//   clr  in  holds the count at 0 and suppresses tick while high
//   tick out one-cycle tempo tick
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // The count is free-running whenever not cleared, so consecutive steps stay
  // phase-locked to the same tick grid with no re-alignment at step boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !clr && (count == LAST);

endmodule

// File: rtl/step_sequencer.sv
// Module: step_sequencer
// Pattern sequencer directly upstream of the synth core. Steps through a
// programmable STEPS-entry pattern at a fixed tempo; for each enabled step it
// holds trig high for GATE_TICKS ticks and presents that step's pulse
// half-period on osc_count for the whole step.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   run         in   1 = play, 0 = stop (restart always begins at step 0)
//   pat_we      in   pattern write strobe
//   pat_addr    in   pattern entry to write
//   pat_en      in   entry enable (0 = rest step)
//   pat_osc     in   entry pulse half-period
//   trig        out  gate to the synth
//   osc_count   out  pulse half-period to the synth
//   step_idx    out  index of the current step
//   step_strobe out  one-cycle pulse at each step start
module step_sequencer
  import seq_pkg::*;
#(
  parameter int STEPS      = 8,
  parameter int TICK_DIV   = 50000,
  parameter int STEP_TICKS = 25,
  parameter int GATE_TICKS = 12,
  parameter int OSC_W      = SEQ_OSC_W,
  parameter int DEF_OSC    = SEQ_DEF_OSC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     pat_we,
  input  logic [$clog2(STEPS)-1:0] pat_addr,
  input  logic                     pat_en,
  input  logic [OSC_W-1:0]         pat_osc,
  output logic                     trig,
  output logic [OSC_W-1:0]         osc_count,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_strobe
);

  localparam int            IW        = $clog2(STEPS);
  localparam int            TW        = $clog2(STEP_TICKS);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_TICKS - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_TICKS - 1);

  // Parameter sanity checks; any violation stops elaboration.
  if (!is_pow2(STEPS) || (STEPS < 2) || (STEPS > 32)) begin : g_bad_steps
    $error("step_sequencer: STEPS must be a power of two in 2..32");
  end
  if ((GATE_TICKS < 1) || (GATE_TICKS >= STEP_TICKS)) begin : g_bad_gate
    $error("step_sequencer: GATE_TICKS must be in 1..STEP_TICKS-1");
  end
  if ((STEP_TICKS < 2) || (TICK_DIV < 2)) begin : g_bad_tempo
    $error("step_sequencer: STEP_TICKS and TICK_DIV must be >= 2");
  end
  if (OSC_W != SEQ_OSC_W) begin : g_bad_osc_w
    $error("step_sequencer: OSC_W must match the synth width in seq_pkg");
  end

  seq_state_t       state, state_d;
  logic [IW-1:0]    step_idx_d;
  logic [TW-1:0]    tick_cnt, tick_cnt_d;
  logic             trig_d;
  logic [OSC_W-1:0] osc_d;
  logic             strobe_d;
  logic             load;
  logic [IW-1:0]    load_idx;
  logic             tick;

  pat_entry_t pattern [STEPS];

  // Prescaler only runs while a sequence is playing, so every run starts
  // with a full tick period in step 0.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // Pattern storage. Reads in the next-state logic see the contents before
  // this edge's write, so a write to the entry being latched in the same
  // cycle only affects the following pass through the pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        pattern[i] <= '{en: 1'b1, osc: SEQ_OSC_W'(DEF_OSC)};
      end
    end else if (pat_we) begin
      pattern[pat_addr] <= '{en: pat_en, osc: pat_osc};
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      step_idx    <= '0;
      tick_cnt    <= '0;
      trig        <= 1'b0;
      osc_count   <= OSC_W'(DEF_OSC);
      step_strobe <= 1'b0;
    end else begin
      state       <= state_d;
      step_idx    <= step_idx_d;
      tick_cnt    <= tick_cnt_d;
      trig        <= trig_d;
      osc_count   <= osc_d;
      step_strobe <= strobe_d;
    end
  end

  // Next-state logic. Leaving run low always wins over tick handling. A step
  // start (load) latches the new entry so trig/osc_count change on the same
  // edge as step_strobe; osc_count otherwise holds, keeping the release pitch.
  always_comb begin
    state_d    = state;
    step_idx_d = step_idx;
    tick_cnt_d = tick_cnt;
    trig_d     = trig;
    osc_d      = osc_count;
    strobe_d   = 1'b0;
    load       = 1'b0;
    load_idx   = step_idx;

    case (state)
      IDLE: begin
        trig_d = 1'b0;
        if (run) begin
          state_d    = GATE;
          step_idx_d = '0;
          tick_cnt_d = '0;
          load       = 1'b1;
          load_idx   = '0;
        end
      end

      GATE: begin
        if (!run) begin
          state_d    = IDLE;
          step_idx_d = '0;
          tick_cnt_d = '0;
          trig_d     = 1'b0;
        end else if (tick) begin
          tick_cnt_d = tick_cnt + 1'b1;
          if (tick_cnt == GATE_LAST) begin
            state_d = REST;
            trig_d  = 1'b0;
          end
        end
      end

      REST: begin
        trig_d = 1'b0;
        if (!run) begin
          state_d    = IDLE;
          step_idx_d = '0;
          tick_cnt_d = '0;
        end else if (tick) begin
          if (tick_cnt == STEP_LAST) begin
            state_d    = GATE;
            step_idx_d = step_idx + 1'b1;
            tick_cnt_d = '0;
            load       = 1'b1;
            load_idx   = step_idx + 1'b1;
          end else begin
            tick_cnt_d = tick_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        step_idx_d = '0;
        tick_cnt_d = '0;
        trig_d     = 1'b0;
      end
    endcase

    if (load) begin
      strobe_d = 1'b1;
      trig_d   = pattern[load_idx].en;
      osc_d    = pattern[load_idx].osc;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Testbench: tb_step_sequencer
// Directed checks of step_sequencer with a shortened tempo
// (TICK_DIV=4, STEP_TICKS=4, GATE_TICKS=2, STEPS=4): one step lasts 16
// cycles, trig is high for the first 8 cycles of an enabled step.
module tb_step_sequencer;

  localparam int STEPS      = 4;
  localparam int TICK_DIV   = 4;
  localparam int STEP_TICKS = 4;
  localparam int GATE_TICKS = 2;
  localparam int OSC_W      = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             pat_we;
  logic [1:0]       pat_addr;
  logic             pat_en;
  logic [OSC_W-1:0] pat_osc;
  logic             trig;
  logic [OSC_W-1:0] osc_count;
  logic [1:0]       step_idx;
  logic             step_strobe;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Expected pattern used in the playback tests.
  int expEn  [4] = '{1, 0, 1, 1};
  int expOsc [4] = '{40, 50, 60, 70};

  step_sequencer #(
    .STEPS      (STEPS),
    .TICK_DIV   (TICK_DIV),
    .STEP_TICKS (STEP_TICKS),
    .GATE_TICKS (GATE_TICKS),
    .OSC_W      (OSC_W),
    .DEF_OSC    (66)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pat_we      (pat_we),
    .pat_addr    (pat_addr),
    .pat_en      (pat_en),
    .pat_osc     (pat_osc),
    .trig        (trig),
    .osc_count   (osc_count),
    .step_idx    (step_idx),
    .step_strobe (step_strobe)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle pattern write.
  task automatic applyStimulus(input int addr, input int en, input int osc);
    pat_we   = 1'b1;
    pat_addr = 2'(addr);
    pat_en   = 1'(en);
    pat_osc  = 8'(osc);
    cyc(1);
    pat_we   = 1'b0;
  endtask

  initial begin
    int strobes;
    int lastCyc;
    int spacingBad;
    int firstCyc;

    rst = 1'b1; run = 1'b0; pat_we = 1'b0; pat_addr = '0; pat_en = 1'b0; pat_osc = '0;
    cyc(2);
    rst = 1'b0;

    // Test 1: reset state, first step timing.
    checkOutput("rst_trig", trig, 0);
    checkOutput("rst_osc", osc_count, 66);
    checkOutput("rst_idx", step_idx, 0);
    checkOutput("rst_strobe", step_strobe, 0);
    cyc(3);
    checkOutput("idle_trig", trig, 0);
    run = 1'b1;
    cyc(1);
    checkOutput("t1_strobe0", step_strobe, 1);
    checkOutput("t1_trig0", trig, 1);
    checkOutput("t1_osc0", osc_count, 66);
    checkOutput("t1_idx0", step_idx, 0);
    cyc(1);
    checkOutput("t1_strobe_1cyc", step_strobe, 0);
    cyc(6);
    checkOutput("t1_trig_c7", trig, 1);
    cyc(1);
    checkOutput("t1_trig_c8", trig, 0);
    cyc(7);
    checkOutput("t1_strobe_c15", step_strobe, 0);
    cyc(1);
    checkOutput("t1_strobe_c16", step_strobe, 1);
    checkOutput("t1_idx_c16", step_idx, 1);
    run = 1'b0;
    cyc(1);
    checkOutput("t1_stop_trig", trig, 0);
    checkOutput("t1_stop_idx", step_idx, 0);

    // Test 2: programmed pattern plays with rests and wrap.
    applyStimulus(0, 1, 40);
    applyStimulus(1, 0, 50);
    applyStimulus(2, 1, 60);
    applyStimulus(3, 1, 70);
    cyc(2);
    run = 1'b1;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t2_strobe_s%0d", k), step_strobe, 1);
      checkOutput($sformatf("t2_idx_s%0d", k), step_idx, k % 4);
      checkOutput($sformatf("t2_osc_s%0d", k), osc_count, expOsc[k % 4]);
      checkOutput($sformatf("t2_trig_s%0d", k), trig, expEn[k % 4]);
      cyc(7);
      checkOutput($sformatf("t2_gate_s%0d", k), trig, expEn[k % 4]);
      cyc(1);
      checkOutput($sformatf("t2_rel_trig_s%0d", k), trig, 0);
      checkOutput($sformatf("t2_rel_osc_s%0d", k), osc_count, expOsc[k % 4]);
      cyc(8);
    end

    // Test 3: drop run mid-GATE of step 2, restart at step 0.
    cyc(16);
    checkOutput("t3_idx2", step_idx, 2);
    checkOutput("t3_trig2", trig, 1);
    cyc(3);
    run = 1'b0;
    cyc(1);
    checkOutput("t3_stop_trig", trig, 0);
    checkOutput("t3_stop_idx", step_idx, 0);
    cyc(3);
    checkOutput("t3_idle_trig", trig, 0);
    run = 1'b1;
    cyc(1);
    checkOutput("t3_restart_strobe", step_strobe, 1);
    checkOutput("t3_restart_idx", step_idx, 0);
    checkOutput("t3_restart_osc", osc_count, 40);

    // Test 4: write ahead of a step, and write in the exact latch cycle.
    cyc(2);
    applyStimulus(1, 1, 99);
    cyc(13);
    checkOutput("t4_idx1", step_idx, 1);
    checkOutput("t4_osc99", osc_count, 99);
    checkOutput("t4_trig99", trig, 1);
    cyc(63);
    applyStimulus(1, 0, 11);
    checkOutput("t4_rbw_strobe", step_strobe, 1);
    checkOutput("t4_rbw_osc", osc_count, 99);
    checkOutput("t4_rbw_trig", trig, 1);
    cyc(64);
    checkOutput("t4_new_idx", step_idx, 1);
    checkOutput("t4_new_osc", osc_count, 11);
    checkOutput("t4_new_trig", trig, 0);
    cyc(7);
    checkOutput("t4_rest_step_trig", trig, 0);

    // Test 5: async reset in the middle of REST.
    cyc(9);
    checkOutput("t5_idx2", step_idx, 2);
    checkOutput("t5_osc60", osc_count, 60);
    cyc(10);
    checkOutput("t5_rest_trig", trig, 0);
    checkOutput("t5_rest_osc", osc_count, 60);
    #2;
    rst = 1'b1;
    run = 1'b0;
    #1;
    checkOutput("t5_async_osc", osc_count, 66);
    checkOutput("t5_async_idx", step_idx, 0);
    checkOutput("t5_async_trig", trig, 0);
    checkOutput("t5_async_strobe", step_strobe, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Test 6: three full loops of a freshly reset pattern, strobe spacing.
    run = 1'b1;
    strobes = 0; lastCyc = -1; spacingBad = 0; firstCyc = -1;
    for (int c = 1; c <= 192; c++) begin
      cyc(1);
      if (step_strobe) begin
        if (lastCyc < 0) firstCyc = c;
        else if (c - lastCyc != 16) spacingBad++;
        checkOutput($sformatf("t6_idx_n%0d", strobes), step_idx, strobes % 4);
        checkOutput($sformatf("t6_osc_n%0d", strobes), osc_count, 66);
        checkOutput($sformatf("t6_trig_n%0d", strobes), trig, 1);
        strobes++;
        lastCyc = c;
      end
    end
    checkOutput("t6_strobe_count", strobes, 12);
    checkOutput("t6_first_strobe", firstCyc, 1);
    checkOutput("t6_spacing_bad", spacingBad, 0);
    run = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
